div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divide sequencer for the EX stage. It owns the single iterative 32-bit divider shared by DIV and DIVU. It latches operands on a start request, runs one restoring-division step per cycle, and handles divide-by-zero, annul (flush) and signed correction. It presents a 64-bit {remainder, quotient} result with a ready level, which EX uses to drop its stall request and write HI/LO.

## Interface

Parameters:
- none; width fixed at 32 (MIPS32 HI/LO).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- start_i  in  1  divide request; EX holds it high until ready_o is seen
- annul_i  in  1  flush; aborts an operation in progress
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- result_o  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}
- ready_o  out  1  result valid
- busy_o  out  1  divider occupied (DIV_ZERO or DIV_ON)

## Operation

States: DIV_FREE, DIV_ZERO, DIV_ON, DIV_END.

**DIV_FREE**
- If start_i=1 and annul_i=0:
  - opdata2_i==0 → go to DIV_ZERO.
  - Otherwise latch operand magnitudes and go to DIV_ON with cnt=0. Magnitude is two's-complement abs when signed_div_i=1 and bit31=1; otherwise the raw value.
- Also latch signed_div_i and both sign bits.
- start_i with annul_i=1 is ignored.

**DIV_ZERO**
- Load quotient=0, remainder=0, go to DIV_END.

**DIV_ON**, each cycle one restoring step, MSB first:
- T = {R[31:0], Q[31]} − {1'b0, D} (33-bit).
- T[32]=1 (borrow): R←{R[30:0], Q[31]}, Q←{Q[30:0], 0}.
- Else: R←T[31:0], Q←{Q[30:0], 1}.
- cnt increments.
- On cnt==31, after the final step, apply signed correction and go to DIV_END:
  - quotient negated if the signs differ;
  - remainder negated if the dividend was negative.
- annul_i=1 or start_i=0 in any DIV_ON cycle → DIV_FREE, no result, ready_o stays 0.

**DIV_END**
- ready_o=1; result_o holds the registered result.
- Stays in DIV_END while start_i=1; annul_i is ignored here.
- start_i=0 → DIV_FREE. ready_o and result_o return to 0 on the same edge.

**Arithmetic and outputs**
- Operands are sampled only on DIV_FREE exit; later input changes are ignored.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. No trap.
- busy_o is decoded combinationally from state.
- ready_o and result_o are registered.

## Timing

- Reset: state DIV_FREE, cnt=0, R=Q=0, result_o=0, ready_o=0, busy_o=0, effective at the first rising edge with rst=1. Reset overrides every state, including mid-operation.
- Normal divide:
  - start_i is sampled in DIV_FREE at edge E0.
  - DIV_ON occupies the 32 cycles after E0.
  - ready_o=1 from edge E0+33.
  - Latency is 33 cycles from sampling to ready.
- Divide-by-zero: ready_o=1 from edge E0+2.
- Minimum repeat: a new start_i is accepted one cycle after start_i falls. The DIV_END→DIV_FREE cycle is mandatory, so back-to-back DIV costs 35 cycles.
- No combinational path from inputs to outputs.

## Structure

- State encodings go in shared `defines.v`: DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
- DivResultReady/NotReady and DivStart/DivStop constants also go in `defines.v`, alongside the existing EXE_DIV_OP/EXE_DIVU_OP.
- One sub-module is natural: `div_step`, a combinational 33-bit subtract/select producing next R, Q.
- The FSM, counter and sign correction stay in div_seq.

## Test plan

- Unsigned 100/7, start held: ready_o rises exactly 33 cycles after sampling; result_o=0x00000002_0000000E.
- Signed −7/2 (0xFFFFFFF9, 2): result_o=0xFFFFFFFF_FFFFFFFD, i.e. remainder −1, quotient −3.
- Divide by zero, opdata2_i=0: ready_o at cycle 2, result_o=0. Divider accepts the next op after start_i drops.
- annul_i pulsed at DIV_ON cycle 10: returns to DIV_FREE, ready_o never asserts. An immediately following DIVU 0xFFFFFFFF/0x10 yields 0x0000000F_0FFFFFFF.
- Signed 0x80000000/0xFFFFFFFF yields 0x00000000_80000000. Holding start_i 5 extra cycles keeps ready_o=1 and result_o stable; start_i low clears both next edge.
- rst asserted at DIV_ON cycle 20: all outputs 0 after that edge. Operand changes during DIV_ON (no annul) do not alter the result.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the iterative 32-bit divide sequencer.
// Holds the FSM state encoding and the two's-complement magnitude/negate helpers.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_t;

    localparam logic [4:0] DIV_LAST_STEP = 5'd31;

    function automatic logic [31:0] negate32(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

    function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] value);
        return (is_signed && value[31]) ? negate32(value) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and shift the next quotient bit in, MSB first.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] diff;

    always_comb begin
        diff = {rem, quo[31]} - {1'b0, divisor};
        if (diff[32]) begin
            rem_next = {rem[30:0], quo[31]};
            quo_next = {quo[30:0], 1'b0};
        end else begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX: latches operands on start, runs 32
// restoring steps, applies sign correction and holds {remainder, quotient} with ready.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_t  state, state_next;
    logic [4:0]  cnt;
    logic [31:0] rem, quo, divisor;
    logic [31:0] rem_next, quo_next;
    logic        op_signed, dividend_neg, divisor_neg;

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_FREE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE:
                if (start_i && !annul_i)
                    state_next = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
            DIV_ZERO:
                state_next = DIV_END;
            DIV_ON:
                if (annul_i || !start_i)        state_next = DIV_FREE;
                else if (cnt == DIV_LAST_STEP)  state_next = DIV_END;
            DIV_END:
                if (!start_i) state_next = DIV_FREE;
            default:
                state_next = DIV_FREE;
        endcase
    end

    assign busy_o = (state == DIV_ZERO) || (state == DIV_ON);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            op_signed    <= 1'b0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            result_o     <= '0;
            ready_o      <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        op_signed    <= signed_div_i;
                        dividend_neg <= opdata1_i[31];
                        divisor_neg  <= opdata2_i[31];
                        cnt          <= '0;
                        rem          <= '0;
                        quo          <= magnitude(signed_div_i, opdata1_i);
                        divisor      <= magnitude(signed_div_i, opdata2_i);
                    end
                end
                DIV_ZERO: begin
                    rem <= '0;
                    quo <= '0;
                end
                DIV_ON: begin
                    if (start_i && !annul_i) begin
                        cnt <= cnt + 5'd1;
                        // Sign correction is folded into the final step so DIV_END only publishes.
                        if (cnt == DIV_LAST_STEP) begin
                            quo <= (op_signed && (dividend_neg != divisor_neg)) ? negate32(quo_next) : quo_next;
                            rem <= (op_signed && dividend_neg) ? negate32(rem_next) : rem_next;
                        end else begin
                            quo <= quo_next;
                            rem <= rem_next;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i) begin
                        result_o <= {rem, quo};
                        ready_o  <= 1'b1;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus randomized
// DIV/DIVU traffic against an arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks = 0;
    int passed = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero; x/0 gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an op and waits for ready; lat counts edges after the sampling edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat, output logic busy_seen);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        step();
        busy_seen = busy_o;
        lat = 0;
        while (!ready_o && lat < 100) begin
            step();
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        step();
        step();
        checks++;
        if ({result_o, ready_o, busy_o} !== 66'd0)
            $display("FAIL reset: got result=%h ready=%b busy=%b expected all 0", result_o, ready_o, busy_o);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_unsigned();
        logic [63:0] res; int lat; logic bsy;
        run_div(32'd100, 32'd7, 1'b0, res, lat, bsy);
        checks++;
        if (lat !== 33) $display("FAIL udiv_latency: got %0d expected 33", lat);
        else passed++;
        checks++;
        if (res !== 64'h00000002_0000000E) $display("FAIL udiv_100_7: got %h expected %h", res, 64'h00000002_0000000E);
        else passed++;
        checks++;
        if (bsy !== 1'b1) $display("FAIL udiv_busy: got %b expected 1", bsy);
        else passed++;
        start_i = 1'b0;
        step();
        checks++;
        if ({ready_o, result_o} !== 65'd0) $display("FAIL udiv_clear: got ready=%b result=%h expected 0", ready_o, result_o);
        else passed++;
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat; logic bsy;
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, res, lat, bsy);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL sdiv_m7_2: got %h expected %h", res, 64'hFFFFFFFF_FFFFFFFD);
        else passed++;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat; logic bsy;
        run_div(32'h12345678, 32'd0, 1'b1, res, lat, bsy);
        checks++;
        if (lat !== 2) $display("FAIL divzero_latency: got %0d expected 2", lat);
        else passed++;
        checks++;
        if (res !== 64'd0) $display("FAIL divzero_result: got %h expected 0", res);
        else passed++;
        start_i = 1'b0;
        step();
        run_div(32'd50, 32'd5, 1'b0, res, lat, bsy);
        checks++;
        if (res !== 64'h00000000_0000000A || lat !== 33)
            $display("FAIL divzero_next: got %h lat=%0d expected %h lat=33", res, lat, 64'h00000000_0000000A);
        else passed++;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_annul();
        logic [63:0] res; int lat; logic bsy; logic ready_seen;
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b0;
        step();
        ready_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            ready_seen |= ready_o;
        end
        annul_i = 1'b1;
        step();
        ready_seen |= ready_o;
        checks++;
        if (busy_o !== 1'b0 || ready_seen !== 1'b0)
            $display("FAIL annul_abort: got busy=%b ready_seen=%b expected 0/0", busy_o, ready_seen);
        else passed++;
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, res, lat, bsy);
        checks++;
        if (res !== 64'h0000000F_0FFFFFFF || lat !== 33)
            $display("FAIL annul_next: got %h lat=%0d expected %h lat=33", res, lat, 64'h0000000F_0FFFFFFF);
        else passed++;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_overflow_hold();
        logic [63:0] res; int lat; logic bsy; logic stable;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, res, lat, bsy);
        checks++;
        if (res !== 64'h00000000_80000000) $display("FAIL sdiv_overflow: got %h expected %h", res, 64'h00000000_80000000);
        else passed++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ready_o !== 1'b1 || result_o !== 64'h00000000_80000000) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) $display("FAIL hold_stable: got ready=%b result=%h expected 1/%h", ready_o, result_o, 64'h00000000_80000000);
        else passed++;
        start_i = 1'b0;
        step();
        checks++;
        if ({ready_o, result_o} !== 65'd0) $display("FAIL hold_clear: got ready=%b result=%h expected 0", ready_o, result_o);
        else passed++;
    endtask

    task automatic test_reset_mid();
        opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd13; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b0;
        step();
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({result_o, ready_o, busy_o} !== 66'd0)
            $display("FAIL reset_mid: got result=%h ready=%b busy=%b expected all 0", result_o, ready_o, busy_o);
        else passed++;
        rst = 1'b0;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_operand_change();
        logic [31:0] a, b;
        logic [63:0] exp;
        int lat;
        a = 32'h87654321; b = 32'h00012345;
        exp = ref_div(a, b, 1'b1);
        opdata1_i = a; opdata2_i = b; signed_div_i = 1'b1;
        start_i = 1'b1; annul_i = 1'b0;
        step();
        lat = 0;
        while (!ready_o && lat < 100) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = 1'($urandom);
            step();
            lat++;
        end
        checks++;
        if (result_o !== exp || lat !== 33)
            $display("FAIL operand_change: got %h lat=%0d expected %h lat=33", result_o, lat, exp);
        else passed++;
        start_i = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic s, bsy;
        logic [63:0] res, exp;
        int lat, exp_lat;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (n % 7 == 0) a = 32'h80000000;
            s = 1'($urandom);
            exp = ref_div(a, b, s);
            exp_lat = (b == 32'd0) ? 2 : 33;
            run_div(a, b, s, res, lat, bsy);
            checks++;
            if (res !== exp || lat !== exp_lat || bsy !== 1'b1)
                $display("FAIL random[%0d] a=%h b=%h s=%b: got %h lat=%0d busy=%b expected %h lat=%0d busy=1",
                         n, a, b, s, res, lat, bsy, exp, exp_lat);
            else passed++;
            start_i = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_overflow_hold();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
